ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Upstream stage of the game-flow top: turns the raw PS/2 keyboard clock/data lines into held-key levels for the seven game keys (A, W, D, X, S, space, esc).
- The screen FSM and the moles screen consume these levels directly.
- Contains a PS/2 frame receiver (synchroniser, glitch filter, watchdog, 11-bit frame FSM) and a scan-code set 2 make/break decoder.

Parameters:
FILTER_LEN, 8, consecutive equal clk samples needed before the filtered PS2_CLK level changes (1..15)
TIMEOUT_CYC, 200000, clk cycles without a falling PS2_CLK edge mid-frame before the frame is aborted (2 ms at 100 MHz)

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  asynchronous, active-low reset
PS2_CLK  input  1  raw PS/2 clock from keyboard, asynchronous
PS2_DATA  input  1  raw PS/2 data from keyboard, asynchronous
key_A  output  1  high while A is held (scan code 1C)
key_W  output  1  high while W is held (1D)
key_D  output  1  high while D is held (23)
key_X  output  1  high while X is held (22)
key_S  output  1  high while S is held (1B)
key_space  output  1  high while space is held (29)
key_esc  output  1  high while esc is held (76)
frame_err  output  1  one-cycle pulse on any rejected frame (bad start, parity, stop or timeout)

Behaviour:
- Reset (reset low, asynchronous) state:
  - all key outputs 0, frame_err 0
  - frame FSM IDLE, decoder NORMAL
  - filter, synchroniser and watchdog cleared; filtered clock level 1
- Input conditioning:
  - PS2_CLK and PS2_DATA each pass through 2-FF synchronisers.
  - The filtered clock follows the synchronised PS2_CLK only after FILTER_LEN consecutive equal samples.
  - A falling edge is a 1->0 change of the filtered clock. Data is sampled from synchronised PS2_DATA in the same cycle.
- Frame FSM (states IDLE, DATA, PARITY, STOP):
  - IDLE: on a falling edge with data=0 (start bit), go to DATA with bit count 0. A start bit of 1 stays in IDLE and pulses frame_err.
  - DATA: 8 edges, LSB first, shifted into an 8-bit register, then PARITY.
  - PARITY: sample the parity bit; odd parity over the 8 data bits plus parity is required. Then STOP.
  - STOP: stop bit must be 1.
  - A good frame emits rx_valid plus the byte for one cycle. A bad parity or stop bit pulses frame_err and discards the byte. The FSM returns to IDLE in all cases.
- Watchdog:
  - Counts cycles while not in IDLE and resets on every falling edge.
  - At TIMEOUT_CYC the FSM aborts to IDLE and frame_err pulses.
- Decoder FSM (states NORMAL, BREAK, EXT, EXT_BREAK), on each rx_valid:
  - F0: NORMAL->BREAK, EXT->EXT_BREAK; BREAK and EXT_BREAK hold.
  - E0: any state -> EXT.
  - Other byte in NORMAL: a listed code sets its key to 1.
  - Other byte in BREAK: a listed code clears its key to 0.
  - Other byte in EXT or EXT_BREAK: ignored.
  - After any non-prefix byte the decoder returns to NORMAL. Unlisted codes (AA, FA, EE, etc.) are ignored but still return it to NORMAL.
  - frame_err forces the decoder to NORMAL; key levels are untouched.
- Latency: key output changes 2 clk cycles after the falling edge that samples the stop bit (one cycle rx_valid register, one cycle key register).
- Boundary conditions:
  - Repeated make (typematic) keeps the key at 1.
  - A break for a key not held keeps it at 0.
  - Keys are independent, so several keys can be high at once.
  - Reset asserted mid-frame discards the partial frame and clears all keys immediately.
  - Host-to-device transmission is not supported; the block never drives PS2_CLK or PS2_DATA.

Optional Feature:
- Macro: KEY_PRESS_PULSE_EN
- Defined: adds output key_press [6:0] (bit order A, W, D, X, S, space, esc).
  - A bit pulses for one cycle, in the same cycle its key level rises 0->1.
  - Typematic repeats produce no pulse. Reset value is 0.
- Undefined: the port and its logic are absent; key levels behave identically.

Decomposition:
- Package ps2_pkg holds:
  - scan-code constants: SC_A 1C, SC_W 1D, SC_D 23, SC_X 22, SC_S 1B, SC_SPACE 29, SC_ESC 76, SC_BREAK F0, SC_EXT E0
  - key index constants 0..6
  - frame FSM and decoder FSM state encodings
- Sub-module ps2_frame_rx: synchroniser, filter, watchdog and frame FSM; outputs rx_byte[7:0], rx_valid, rx_err. The top holds only the decoder FSM and key registers.

Test Plan:
- Frame 1C (start 0, bits 0011_1000 LSB first, parity 0, stop 1) -> key_A goes 1 exactly 2 cycles after the stop-bit edge; frame_err stays 0.
- Frames 1C, F0, 1C -> key_A goes 1 then 0. With KEY_PRESS_PULSE_EN, key_press[0] pulses exactly once.
- Frames 29, 76, then F0 29 -> key_space and key_esc both 1, then key_space 0 while key_esc stays 1.
- Frames E0 75 (up arrow) then E0 F0 75, then 1D -> no key changes during the E0 sequences; key_W=1 after 1D.
- Frame 1C with flipped parity -> frame_err one pulse, key_A stays 0. Then 4 bits followed by silence for TIMEOUT_CYC -> frame_err pulse; a following valid 1B frame sets key_S=1.
- 2-cycle glitch on PS2_CLK (FILTER_LEN=8) -> no bit sampled. Reset asserted while key_D=1 mid-frame -> all keys 0 asynchronously, next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard front end: scan codes, key indices,
// frame-receiver and make/break decoder state encodings, and a scan-code to
// key-mask lookup used by the decoder.
package ps2_pkg;

    // Scan-code set 2 values of interest
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_X     = 8'h22;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // Bit positions in the 7-bit key vector
    localparam int KEY_A     = 0;
    localparam int KEY_W     = 1;
    localparam int KEY_D     = 2;
    localparam int KEY_X     = 3;
    localparam int KEY_S     = 4;
    localparam int KEY_SPACE = 5;
    localparam int KEY_ESC   = 6;
    localparam int NUM_KEYS  = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    typedef enum logic [1:0] {
        DEC_NORMAL,
        DEC_BREAK,
        DEC_EXT,
        DEC_EXT_BREAK
    } dec_state_t;

    // One-hot key mask for a scan code; all-zero for codes we do not track.
    function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [7:0] code);
        logic [NUM_KEYS-1:0] m;
        m = '0;
        case (code)
            SC_A:     m[KEY_A]     = 1'b1;
            SC_W:     m[KEY_W]     = 1'b1;
            SC_D:     m[KEY_D]     = 1'b1;
            SC_X:     m[KEY_X]     = 1'b1;
            SC_S:     m[KEY_S]     = 1'b1;
            SC_SPACE: m[KEY_SPACE] = 1'b1;
            SC_ESC:   m[KEY_ESC]   = 1'b1;
            default:  m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: sync + glitch filter + watchdog + 11-bit frame FSM.
// Latency: rx_valid/rx_err one cycle after the filtered falling edge of the stop bit.
// Backpressure: none; the keyboard cannot be stalled, every byte is presented once.
// Ports: clk, reset (async active-low), ps2_clk/ps2_data raw pins in;
//        rx_byte[7:0] + rx_valid (good frame), rx_err (bad start/parity/stop/timeout) out.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]      clk_sync;
    logic [1:0]      dat_sync;
    logic [3:0]      filt_cnt;
    logic            filt_clk;
    logic            filt_clk_q;
    logic            fall;
    logic            sdata;
    frame_state_t    state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            par_ok;
    logic [WD_W-1:0] wd_cnt;

    assign fall    = filt_clk_q & ~filt_clk;
    assign sdata   = dat_sync[1];
    assign rx_byte = shift;

    // Synchronisers reset to the idle bus level so release of reset never
    // looks like a clock edge. The filtered level only moves after
    // FILTER_LEN consecutive samples that disagree with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            filt_cnt   <= '0;
            filt_clk   <= 1'b1;
            filt_clk_q <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            dat_sync   <= {dat_sync[0], ps2_data};
            filt_clk_q <= filt_clk;
            if (clk_sync[1] == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == 4'(FILTER_LEN - 1)) begin
                filt_clk <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            par_ok   <= 1'b0;
            wd_cnt   <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;

            if (state == ST_IDLE || fall)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 1'b1;

            if (state != ST_IDLE && !fall && wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
                // Keyboard went quiet mid-frame: drop the partial byte.
                state  <= ST_IDLE;
                rx_err <= 1'b1;
            end else if (fall) begin
                case (state)
                    ST_IDLE: begin
                        if (!sdata) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end else begin
                            rx_err <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shift   <= {sdata, shift[7:1]};  // LSB arrives first
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_ok <= ^{sdata, shift};       // odd parity -> XOR is 1
                        state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (sdata && par_ok)
                            rx_valid <= 1'b1;
                        else
                            rx_err <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard to held-key levels for A, W, D, X, S, space, esc (scan-code set 2 make/break).
// Latency: key level changes 2 cycles after the filtered falling edge of the stop bit.
// Backpressure: none; outputs are levels, frame_err is a one-cycle pulse.
// Ports: clk, reset (async active-low), PS2_CLK/PS2_DATA raw pins in;
//        key_* levels, frame_err pulse out; key_press[6:0] rising-edge pulses
//        (A,W,D,X,S,space,esc at bits 0..6) only when KEY_PRESS_PULSE_EN is defined.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic       key_A,
    output logic       key_W,
    output logic       key_D,
    output logic       key_X,
    output logic       key_S,
    output logic       key_space,
    output logic       key_esc,
    output logic       frame_err
`ifdef KEY_PRESS_PULSE_EN
    ,
    output logic [6:0] key_press
`endif
);

    logic [7:0]          rx_byte;
    logic                rx_valid;
    logic                rx_err;
    dec_state_t          dec_state;
    logic [NUM_KEYS-1:0] keys;
    logic [NUM_KEYS-1:0] code_mask;
    logic                is_prefix;
    logic [NUM_KEYS-1:0] make_mask;

    ps2_frame_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_rx (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (PS2_CLK),
        .ps2_data (PS2_DATA),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_err   (rx_err)
    );

    always_comb begin
        code_mask = key_onehot(rx_byte);
        is_prefix = (rx_byte == SC_BREAK) || (rx_byte == SC_EXT);
        make_mask = '0;
        if (rx_valid && !is_prefix && dec_state == DEC_NORMAL)
            make_mask = code_mask;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dec_state <= DEC_NORMAL;
            keys      <= '0;
        end else if (rx_err) begin
            // A lost frame may have been a prefix; restart cleanly, keep levels.
            dec_state <= DEC_NORMAL;
        end else if (rx_valid) begin
            if (rx_byte == SC_BREAK) begin
                if (dec_state == DEC_NORMAL)
                    dec_state <= DEC_BREAK;
                else if (dec_state == DEC_EXT)
                    dec_state <= DEC_EXT_BREAK;
            end else if (rx_byte == SC_EXT) begin
                dec_state <= DEC_EXT;
            end else begin
                // Extended codes never touch the game keys.
                if (dec_state == DEC_BREAK)
                    keys <= keys & ~code_mask;
                else
                    keys <= keys | make_mask;
                dec_state <= DEC_NORMAL;
            end
        end
    end

`ifdef KEY_PRESS_PULSE_EN
    // Only keys not already held pulse, so typematic repeats stay silent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            key_press <= '0;
        else
            key_press <= make_mask & ~keys;
    end
`endif

    assign key_A     = keys[KEY_A];
    assign key_W     = keys[KEY_W];
    assign key_D     = keys[KEY_D];
    assign key_X     = keys[KEY_X];
    assign key_S     = keys[KEY_S];
    assign key_space = keys[KEY_SPACE];
    assign key_esc   = keys[KEY_ESC];
    assign frame_err = rx_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed frames plus random byte streams,
// compared against a byte-level make/break model of the keyboard protocol.
// Expected key latency from a raw PS2_CLK fall: 2 sync + FILTER_LEN filter + 1 rx_valid + 1 key.
module tb_ps2_key_decoder;

    localparam int FILT = 8;
    localparam int TMO  = 2000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic PS2_CLK = 1'b1;
    logic PS2_DATA = 1'b1;
    logic key_A, key_W, key_D, key_X, key_S, key_space, key_esc, frame_err;
`ifdef KEY_PRESS_PULSE_EN
    logic [6:0] key_press;
`endif

    ps2_key_decoder #(
        .FILTER_LEN  (FILT),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DATA  (PS2_DATA),
        .key_A     (key_A),
        .key_W     (key_W),
        .key_D     (key_D),
        .key_X     (key_X),
        .key_S     (key_S),
        .key_space (key_space),
        .key_esc   (key_esc),
        .frame_err (frame_err)
`ifdef KEY_PRESS_PULSE_EN
        ,
        .key_press (key_press)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_fall = 0;
    int rise_a_cyc = -1;
    int err_cnt = 0;
    int exp_err = 0;
    int press_cnt = 0;
    int exp_press = 0;

    logic [6:0] keys_v;
    logic       prev_a = 1'b0;
    assign keys_v = {key_esc, key_space, key_S, key_X, key_D, key_W, key_A};

    // Reference model state: held keys plus pending prefix flags.
    logic [6:0] mdl_keys = '0;
    bit         m_ext = 0;
    bit         m_brk = 0;

    logic [7:0] pool [0:12] = '{8'h1C, 8'h1D, 8'h23, 8'h22, 8'h1B, 8'h29, 8'h76,
                                8'hF0, 8'hE0, 8'h75, 8'hAA, 8'hFA, 8'hEE};

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (key_A && !prev_a) rise_a_cyc = cyc;
        prev_a = key_A;
`ifdef KEY_PRESS_PULSE_EN
        press_cnt += $countones(key_press);
`endif
    end

    always @(negedge clk) if (frame_err) err_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int code_idx(input logic [7:0] c);
        case (c)
            8'h1C: return 0;
            8'h1D: return 1;
            8'h23: return 2;
            8'h22: return 3;
            8'h1B: return 4;
            8'h29: return 5;
            8'h76: return 6;
            default: return -1;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] b, input bit err);
        int idx;
        if (err) begin
            m_ext = 0;
            m_brk = 0;
            exp_err++;
            return;
        end
        if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1;
            m_brk = 0;
        end else begin
            idx = code_idx(b);
            if (!m_ext && idx >= 0) begin
                if (!m_brk && !mdl_keys[idx]) exp_press++;
                mdl_keys[idx] = !m_brk;
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    // Data changes while the clock is high; the keyboard drives the fall.
    task automatic send_bit(input logic b, input int half);
        PS2_DATA = b;
        repeat (half) @(posedge clk);
        #1 PS2_CLK = 1'b0;
        last_fall = cyc;
        repeat (half) @(posedge clk);
        #1 PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit badpar, input int half);
        logic p;
        p = ~(^b) ^ badpar;
        send_bit(1'b0, half);
        for (int i = 0; i < 8; i++) send_bit(b[i], half);
        send_bit(p, half);
        send_bit(1'b1, half);
        PS2_DATA = 1'b1;
        repeat (half) @(posedge clk);
        #1;
    endtask

    task automatic do_frame(input string tag, input logic [7:0] b, input bit badpar, input int half);
        send_frame(b, badpar, half);
        model_byte(b, badpar);
        check_eq({tag, "_keys"}, 32'(keys_v), 32'(mdl_keys));
        check_eq({tag, "_errs"}, err_cnt, exp_err);
    endtask

    initial begin
        logic [7:0] b;
        bit         bp;
        int         half;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_keys", 32'(keys_v), 32'h0);
        check_eq("reset_err", 32'(frame_err), 32'h0);
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_eq("idle_keys", 32'(keys_v), 32'h0);
        check_eq("idle_errs", err_cnt, 0);

        // Single make with latency check on the stop-bit edge
        do_frame("make_A", 8'h1C, 0, 20);
        check_eq("lat_A", rise_a_cyc - last_fall, FILT + 4);

        do_frame("rep_A", 8'h1C, 0, 20);
        do_frame("brk_A0", 8'hF0, 0, 20);
        do_frame("brk_A1", 8'h1C, 0, 20);
        do_frame("brk_A_again0", 8'hF0, 0, 20);
        do_frame("brk_A_again1", 8'h1C, 0, 20);

        do_frame("make_sp", 8'h29, 0, 20);
        do_frame("make_esc", 8'h76, 0, 20);
        do_frame("brk_sp0", 8'hF0, 0, 20);
        do_frame("brk_sp1", 8'h29, 0, 20);

        do_frame("ext_up0", 8'hE0, 0, 20);
        do_frame("ext_up1", 8'h75, 0, 20);
        do_frame("extb_up0", 8'hE0, 0, 20);
        do_frame("extb_up1", 8'hF0, 0, 20);
        do_frame("extb_up2", 8'h75, 0, 20);
        do_frame("make_W", 8'h1D, 0, 20);

        do_frame("badpar_A", 8'h1C, 1, 20);

        // Four bits then silence: watchdog must abort the frame
        send_bit(1'b0, 20);
        send_bit(1'b1, 20);
        send_bit(1'b0, 20);
        send_bit(1'b1, 20);
        PS2_DATA = 1'b1;
        repeat (TMO + 100) @(posedge clk);
        #1;
        model_byte(8'h00, 1);
        check_eq("tmo_errs", err_cnt, exp_err);
        check_eq("tmo_keys", 32'(keys_v), 32'(mdl_keys));
        do_frame("make_S", 8'h1B, 0, 20);

        // Short clock glitch with data low must not be taken as a start bit
        PS2_DATA = 1'b0;
        repeat (3) @(posedge clk);
        #1 PS2_CLK = 1'b0;
        repeat (2) @(posedge clk);
        #1 PS2_CLK = 1'b1;
        PS2_DATA = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        do_frame("glitch_D", 8'h23, 0, 20);

        // Asynchronous reset in the middle of a frame
        send_bit(1'b0, 20);
        send_bit(1'b1, 20);
        send_bit(1'b0, 20);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_keys", 32'(keys_v), 32'h0);
        check_eq("arst_err", 32'(frame_err), 32'h0);
        PS2_DATA = 1'b1;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        mdl_keys = '0;
        m_ext = 0;
        m_brk = 0;
        repeat (20) @(posedge clk);
        #1;
        do_frame("post_rst_D", 8'h23, 0, 20);

        // Random byte streams with occasional parity errors and varied bit rates
        for (int n = 0; n < 45; n++) begin
            b    = ($urandom_range(0, 5) == 0) ? 8'($urandom) : pool[$urandom_range(0, 12)];
            bp   = ($urandom_range(0, 9) == 0);
            half = $urandom_range(12, 25);
            do_frame("rnd", b, bp, half);
        end

`ifdef KEY_PRESS_PULSE_EN
        check_eq("press_pulses", press_cnt, exp_press);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
